// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg: shared CPU-bus addresses and the sprite DMA state type
package nes_bus_pkg;

    localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// oam_dma: halts the CPU and copies one 256-byte page to OAMDATA
module oam_dma
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] OAMDMA_REG  = OAMDMA_ADDR,
    parameter logic [15:0] OAMDATA_REG = OAMDATA_ADDR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  bus_rdata,
    output logic [15:0] bus_addr,
    output logic        bus_we,
    output logic [7:0]  bus_wdata,
    output logic        cpu_rdy,
    output logic        dma_active
);

    dma_state_t r_state;
    logic       r_parity;
    logic [7:0] r_page;
    logic [7:0] r_count;
    logic [7:0] r_byte_q;
    logic       w_idle;

    assign w_idle = (r_state == IDLE);

    // Bus is a CPU pass-through when idle; otherwise the engine drives it
    always_comb begin
        bus_addr   = w_idle ? cpu_addr :
                     (r_state == WRITE) ? OAMDATA_REG :
                     {r_page, (r_state == READ) ? r_count : 8'h00};
        bus_we     = w_idle ? cpu_we : (r_state == WRITE);
        bus_wdata  = w_idle ? cpu_wdata : r_byte_q;
        cpu_rdy    = w_idle;
        dma_active = !w_idle;
    end

    // Transfer FSM; everything freezes on cycles without cpu_ce
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_parity <= 1'b0;
            r_page   <= 8'h00;
            r_count  <= 8'h00;
            r_byte_q <= 8'h00;
        end else if (cpu_ce) begin
            r_parity <= ~r_parity;
            case (r_state)
                IDLE: begin
                    if (cpu_we && cpu_addr == OAMDMA_REG) begin
                        r_page  <= cpu_wdata;
                        r_count <= 8'h00;
                        r_state <= HALT;
                    end
                end
                // parity flips this cycle, so current 1 means next cycle is a get cycle
                HALT:  r_state <= r_parity ? READ : ALIGN;
                ALIGN: r_state <= READ;
                READ: begin
                    r_byte_q <= bus_rdata;
                    r_state  <= WRITE;
                end
                WRITE: begin
                    if (r_count == 8'hFF) begin
                        r_state <= IDLE;
                    end else begin
                        r_count <= r_count + 8'd1;
                        r_state <= READ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite DMA engine for the CPU bus. It sits between the 6502 core and the CPU memory-map decoder (`WRAM_mapper`).
- On a CPU write to 0x4014 it halts the CPU and copies 256 bytes from CPU page `$XX00–$XXFF` to the PPU OAMDATA register (0x2004).
- It owns the bus for the duration of the copy, alternating read and write cycles, then returns the bus to the CPU.

## Interface
Parameters:
- `OAMDMA_REG`, 16'h4014, trigger address.
- `OAMDATA_REG`, 16'h2004, destination address.

Ports:
- `clk`  in  1  system clock. One clock; reset is asynchronous and active-low.
- `reset_n`  in  1  asynchronous active-low reset.
- `cpu_ce`  in  1  CPU cycle enable. State advances only when this is 1.
- `cpu_addr`  in  16  CPU address.
- `cpu_we`  in  1  CPU write strobe.
- `cpu_wdata`  in  8  CPU write data.
- `bus_rdata`  in  8  read data returned by the memory map, valid within the same cycle.
- `bus_addr`  out  16  address to the memory map.
- `bus_we`  out  1  write strobe to the memory map.
- `bus_wdata`  out  8  write data to the memory map.
- `cpu_rdy`  out  1  0 = CPU halted.
- `dma_active`  out  1  1 while DMA owns the bus.

## Operation
- States: `IDLE`, `HALT`, `ALIGN`, `READ`, `WRITE`.
- `parity`: a 1-bit flop that toggles on every `cpu_ce` cycle. 0 = get cycle, 1 = put cycle.
- In `IDLE`:
  - The bus is a pass-through: `bus_addr = cpu_addr`, `bus_we = cpu_we`, `bus_wdata = cpu_wdata`.
  - The write to 0x4014 also passes through to the mapper, which ignores it.
- Trigger: `cpu_ce & cpu_we & cpu_addr == OAMDMA_REG` while in `IDLE`.
  - Latches `page = cpu_wdata`.
  - Clears `count` (8 bits).
  - Next state: `HALT`.
- `HALT`: one dummy cycle. `bus_we = 0`, `bus_addr = {page, 8'h00}`.
  - Next state is `READ` if `parity` in the next cycle is 0, else `ALIGN`.
- `ALIGN`: one dummy cycle, same bus drive as `HALT`. Next state: `READ`.
- `READ`: `bus_addr = {page, count}`, `bus_we = 0`.
  - At the end of the cycle, `bus_rdata` is latched into `byte_q`.
  - Next state: `WRITE`.
- `WRITE`: `bus_addr = OAMDATA_REG`, `bus_we = 1`, `bus_wdata = byte_q`.
  - If `count == 8'hFF`: next state `IDLE`.
  - Otherwise: `count` increments and next state is `READ`.
- `count` is 8 bits and never carries into `page`. The source address stays inside the page.
- `cpu_rdy = 0` and `dma_active = 1` in every state except `IDLE`. The CPU bus inputs are ignored while active.
- A write to 0x4014 during DMA cannot occur, because the CPU is halted. If one is presented anyway, it is ignored.
- All state, `parity`, `count`, `page` and `byte_q` hold when `cpu_ce = 0`. The outputs stay stable during stalls.

## Timing
- Reset values: state `IDLE`, `parity` 0, `count` 0, `page` 0, `byte_q` 0, `cpu_rdy` 1, `dma_active` 0.
  - `bus_*` outputs follow the pass-through during reset.
- Outputs are combinational from state and registers. There are no extra pipeline stages.
- Latency: `cpu_rdy` falls in the first `cpu_ce` cycle after the trigger cycle.
- Length: total halted length is 513 `cpu_ce` cycles (no `ALIGN`) or 514 (with `ALIGN`).
- Release: `cpu_rdy` rises in the `cpu_ce` cycle after the final `WRITE`.
- Exactly 256 cycles have `bus_we = 1`, all to 0x2004, in ascending source order `$XX00 → $XXFF`.
- Trigger cycle with `cpu_ce = 0`: no trigger.
- `reset_n` low mid-transfer: immediate return to reset values. No further writes are issued, and the bus returns to pass-through.

## Structure
- Shared package `nes_bus_pkg` holds:
  - `OAMDMA_ADDR` and `OAMDATA_ADDR` constants, which are the defaults of the parameters above.
  - The `dma_state_t` enum.
- Single module, one FSM. No sub-module is warranted.
- In the top level, the CPU-to-mapper connection is rerouted through `oam_dma`:
  - `bus_*` drive the mapper's `addr`/`WE`/data.
  - `cpu_rdy` gates the 6502.

## Test plan
- Reset: hold `reset_n` low, then release. Required response: `cpu_rdy` = 1, `dma_active` = 0, `bus_addr` tracks `cpu_addr`.
- Even start: write 0x02 to 0x4014 so that the cycle after `HALT` has `parity` 0. Required response:
  - 513 halted cycles.
  - 256 writes to 0x2004 with data equal to the RAM contents at 0x0200..0x02FF, in order.
- Odd start: same as even start, but shifted by one cycle. Required response: one `ALIGN` cycle, 514 halted cycles, the same data sequence.
- `cpu_ce` duty 1/3 with random gaps. Required response:
  - Identical write sequence and cycle counts, measured in `cpu_ce` cycles.
  - Outputs frozen during the gaps.
- Page 0xFF. Required response: reads 0xFF00..0xFFFF (PRG ROM); the last read is 0xFFFF; no access to 0x0000; the DMA returns to `IDLE`.
- Reset asserted at write #100. Required response:
  - `dma_active` = 0 and `cpu_rdy` = 1 immediately.
  - No further 0x2004 writes.
  - A new 0x4014 write then performs a full 256-byte transfer.
